// File: rtl/led_pkg.sv
// Shared constants for the LED fader block on the 12 MHz board design.
// CLK_HZ   : system clock frequency
// LED_CH   : number of LED channels driven by the fader
// *_DEF    : default brightness resolution and fade timing
package led_pkg;

  localparam int CLK_HZ       = 12_000_000;
  localparam int LED_CH       = 4;
  localparam int PWM_BITS_DEF = 8;
  // 255 steps * 11718 cycles / 12 MHz is roughly a 250 ms full ramp.
  localparam int FADE_DIV_DEF = 11718;
  localparam int STEP_DEF     = 1;

endpackage

// File: rtl/led_fade_ch.sv
// One fader channel: holds the on/off target, the brightness level, the
// clamped step toward the target and the registered PWM comparator.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   pattern_valid  : strobe qualifying pattern_bit
//   pattern_bit    : new target for this channel (1 = full on)
//   fade_tick      : level update enable, one cycle per fade period
//   pwm_cnt        : shared free-running PWM counter
//   level          : current brightness level (registered)
//   led            : PWM output, registered (level > pwm_cnt)
//   mismatch_next  : next level differs from next target (feeds busy)
module led_fade_ch
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pattern_valid,
  input  logic                pattern_bit,
  input  logic                fade_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] level,
  output logic                led,
  output logic                mismatch_next
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic                target_on;
  logic                target_on_next;
  logic [PWM_BITS-1:0] target_next;
  logic [PWM_BITS-1:0] level_next;

  // Move cur one STEP toward tgt without passing it. One headroom bit plus a
  // sign bit keep cur+STEP and cur-STEP exact before the clamp.
  function automatic logic [PWM_BITS-1:0] step_clamp(
    input logic [PWM_BITS-1:0] cur,
    input logic [PWM_BITS-1:0] tgt
  );
    logic signed [PWM_BITS+1:0] cur_s;
    logic signed [PWM_BITS+1:0] tgt_s;
    logic signed [PWM_BITS+1:0] step_s;
    logic signed [PWM_BITS+1:0] up_s;
    logic signed [PWM_BITS+1:0] dn_s;
    logic [PWM_BITS-1:0]        res;
    cur_s  = signed'({2'b00, cur});
    tgt_s  = signed'({2'b00, tgt});
    step_s = signed'((PWM_BITS+2)'(STEP));
    up_s   = cur_s + step_s;
    dn_s   = cur_s - step_s;
    res    = cur;
    if (cur_s < tgt_s) begin
      res = (up_s > tgt_s) ? tgt : up_s[PWM_BITS-1:0];
    end else if (cur_s > tgt_s) begin
      res = (dn_s < tgt_s) ? tgt : dn_s[PWM_BITS-1:0];
    end
    return res;
  endfunction

  // A strobe coincident with fade_tick steps toward the new target.
  always_comb begin
    target_on_next = pattern_valid ? pattern_bit : target_on;
    target_next    = target_on_next ? MAX : '0;
    level_next     = fade_tick ? step_clamp(level, target_next) : level;
    mismatch_next  = (level_next != target_next);
  end

  // Stage boundary: target, level and PWM output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_on <= 1'b0;
      level     <= '0;
      led       <= 1'b0;
    end else begin
      target_on <= target_on_next;
      level     <= level_next;
      led       <= (level > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_fader.sv
// Four-channel PWM fader: each new pattern ramps every LED toward full on or
// full off, one STEP per fade tick, so patterns cross-fade.
// Ports:
//   clk            : 12 MHz system clock
//   rst            : asynchronous active-high reset
//   pattern_valid  : single-cycle strobe qualifying pattern
//   pattern[3:0]   : target pattern, bit i set = LED i fades to full on
//   led[3:0]       : registered PWM drive
//   busy           : registered, high while any level differs from its target
//   levels         : current levels, channel i at [i*PWM_BITS +: PWM_BITS]
module led_fader
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int FADE_DIV = FADE_DIV_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pattern_valid,
  input  logic [LED_CH-1:0]          pattern,
  output logic [LED_CH-1:0]          led,
  output logic                       busy,
  output logic [LED_CH*PWM_BITS-1:0] levels
);

  localparam int                  FW       = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [FW-1:0]       FADE_END = FW'(FADE_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PWM_BITS-1:0] PWM_END  = MAX - 1'b1;

  logic [FW-1:0]       fade_cnt;
  logic                fade_tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [LED_CH-1:0]   mismatch_next;

  // Fade timebase runs freely; a strobe does not resync it.
  assign fade_tick = (fade_cnt == FADE_END);

  // Stage boundary: shared counters and busy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fade_cnt <= '0;
      pwm_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      fade_cnt <= fade_tick ? '0 : fade_cnt + 1'b1;
      // Period of MAX cycles so level MAX compares above every count.
      pwm_cnt  <= (pwm_cnt == PWM_END) ? '0 : pwm_cnt + 1'b1;
      busy     <= |mismatch_next;
    end
  end

  for (genvar i = 0; i < LED_CH; i++) begin : g_ch
    led_fade_ch #(
      .PWM_BITS (PWM_BITS),
      .STEP     (STEP)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .pattern_valid (pattern_valid),
      .pattern_bit   (pattern[i]),
      .fade_tick     (fade_tick),
      .pwm_cnt       (pwm_cnt),
      .level         (levels[i*PWM_BITS +: PWM_BITS]),
      .led           (led[i]),
      .mismatch_next (mismatch_next[i])
    );
  end

endmodule

// File: tb/tb_led_fader.sv
module tb_led_fader;

  localparam int PB   = 4;
  localparam int FD   = 4;
  localparam int MAXV = 15;

  logic          clk;
  logic          rst;
  logic          pattern_valid;
  logic [3:0]    pattern;
  logic [3:0]    led_a,    led_b;
  logic          busy_a,   busy_b;
  logic [15:0]   levels_a, levels_b;

  int n_checks;
  int n_fail;

  // Reference state: index 0 = STEP 1 instance, index 1 = STEP 4 instance.
  int         m_step [2];
  int         m_tgt  [2][4];
  int         m_lvl  [2][4];
  logic [3:0] m_led  [2];
  logic       m_busy [2];
  int         m_fc;
  int         m_pc;

  led_fader #(.PWM_BITS(PB), .FADE_DIV(FD), .STEP(1)) dut_a (
    .clk(clk), .rst(rst), .pattern_valid(pattern_valid), .pattern(pattern),
    .led(led_a), .busy(busy_a), .levels(levels_a));

  led_fader #(.PWM_BITS(PB), .FADE_DIV(FD), .STEP(4)) dut_b (
    .clk(clk), .rst(rst), .pattern_valid(pattern_valid), .pattern(pattern),
    .led(led_b), .busy(busy_b), .levels(levels_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_step[0] = 1;
    m_step[1] = 4;
    m_fc = 0;
    m_pc = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_tgt[k][i] = 0;
        m_lvl[k][i] = 0;
      end
      m_led[k]  = 4'b0000;
      m_busy[k] = 1'b0;
    end
  endtask

  // One active clock edge of the specified behaviour.
  task automatic model_edge(input logic pv, input logic [3:0] pat);
    bit tick;
    tick = (m_fc == FD - 1);
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_led[k][i] = (m_lvl[k][i] > m_pc);
        if (pv) m_tgt[k][i] = pat[i] ? MAXV : 0;
        if (tick) begin
          if (m_lvl[k][i] < m_tgt[k][i])
            m_lvl[k][i] = (m_lvl[k][i] + m_step[k] > m_tgt[k][i]) ? m_tgt[k][i] : m_lvl[k][i] + m_step[k];
          else if (m_lvl[k][i] > m_tgt[k][i])
            m_lvl[k][i] = (m_lvl[k][i] - m_step[k] < m_tgt[k][i]) ? m_tgt[k][i] : m_lvl[k][i] - m_step[k];
        end
        if (m_lvl[k][i] != m_tgt[k][i]) m_busy[k] = 1'b1;
      end
    end
    m_fc = (m_fc + 1) % FD;
    m_pc = (m_pc + 1) % MAXV;
  endtask

  function automatic logic [15:0] exp_levels(input int k);
    logic [15:0] r;
    int          v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      v = m_lvl[k][i];
      r[i*4 +: 4] = v[3:0];
    end
    return r;
  endfunction

  task automatic compare_all();
    chk("levels_s1", levels_a, exp_levels(0));
    chk("led_s1",    led_a,    m_led[0]);
    chk("busy_s1",   busy_a,   m_busy[0]);
    chk("levels_s4", levels_b, exp_levels(1));
    chk("led_s4",    led_b,    m_led[1]);
    chk("busy_s4",   busy_b,   m_busy[1]);
  endtask

  // Called at a negedge; applies inputs for the next posedge, returns at the
  // following negedge after checking outputs.
  task automatic tick_cycle(input logic pv, input logic [3:0] pat);
    pattern_valid = pv;
    pattern       = pat;
    @(posedge clk);
    model_edge(pv, pat);
    @(negedge clk);
    pattern_valid = 1'b0;
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_led_s1"},    led_a,    0);
    chk({tag, "_busy_s1"},   busy_a,   0);
    chk({tag, "_levels_s1"}, levels_a, 0);
    chk({tag, "_led_s4"},    led_b,    0);
    chk({tag, "_busy_s4"},   busy_b,   0);
    chk({tag, "_levels_s4"}, levels_b, 0);
  endtask

  // Assert reset between clock edges, check the outputs clear at once and
  // stay clear while held, then release at a negedge.
  task automatic async_reset(input int hold);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_async");
    model_reset();
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1 check_all_zero("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, output int used);
    used = 0;
    do begin
      tick_cycle(1'b0, 4'b0000);
      used++;
    end while ((busy_a || busy_b) && used < budget);
    chk("idle_timeout", {30'd0, busy_a, busy_b}, 0);
  endtask

  initial begin
    int          used;
    int          cnt;
    int          mx;
    int          guard;
    logic [3:0]  others;
    logic [3:0]  prev;
    int          seen[$];
    int          exp_seq[3];

    n_checks = 0;
    n_fail   = 0;
    exp_seq  = '{8, 12, 15};
    model_reset();
    rst = 1'b1;
    pattern_valid = 1'b0;
    pattern = 4'b0000;

    // Power-on reset state.
    @(negedge clk);
    @(negedge clk);
    check_all_zero("por");
    rst = 1'b0;

    // Single LED fades fully on.
    tick_cycle(1'b1, 4'b0001);
    chk("busy_after_strobe", busy_a, 1);
    run_until_idle(200, used);
    chk("ramp_level_s1", levels_a, 16'h000F);
    chk("ramp_cycles_ok", (used >= 56 && used <= 64), 1);
    cnt = 0;
    others = '0;
    for (int c = 0; c < MAXV; c++) begin
      tick_cycle(1'b0, 4'b0000);
      cnt += int'(led_a[0]);
      others |= {led_a[3:1], 1'b0};
    end
    chk("duty_full_on", cnt, MAXV);
    chk("others_off", others, 0);

    // Retarget mid-fade: down from 7 never goes above 7.
    tick_cycle(1'b1, 4'b0000);
    run_until_idle(200, used);
    tick_cycle(1'b1, 4'b0001);
    guard = 0;
    while (levels_a[3:0] != 4'd7 && guard < 100) begin
      tick_cycle(1'b0, 4'b0000);
      guard++;
    end
    chk("reach_7", levels_a[3:0], 7);
    tick_cycle(1'b1, 4'b0000);
    mx = int'(levels_a[3:0]);
    guard = 0;
    while ((busy_a || busy_b) && guard < 100) begin
      tick_cycle(1'b0, 4'b0000);
      if (int'(levels_a[3:0]) > mx) mx = int'(levels_a[3:0]);
      guard++;
    end
    chk("retarget_max", mx, 7);
    chk("retarget_final", levels_a, 0);
    chk("retarget_busy", busy_a, 0);

    // STEP 4 with the strobe landing on a fade tick.
    guard = 0;
    while (m_fc != FD - 1 && guard < 10) begin
      tick_cycle(1'b0, 4'b0000);
      guard++;
    end
    tick_cycle(1'b1, 4'b1111);
    chk("coincident_s4", levels_b, 16'h4444);
    chk("coincident_s1", levels_a, 16'h1111);
    prev = levels_b[3:0];
    guard = 0;
    while ((busy_a || busy_b) && guard < 200) begin
      tick_cycle(1'b0, 4'b0000);
      if (levels_b[3:0] != prev) seen.push_back(int'(levels_b[3:0]));
      prev = levels_b[3:0];
      guard++;
    end
    chk("s4_seq_len", seen.size(), 3);
    for (int j = 0; j < 3; j++) begin
      if (j < seen.size()) chk("s4_seq_val", seen[j], exp_seq[j]);
    end
    chk("s4_final", levels_b, 16'hFFFF);

    // Random strobes against the reference.
    for (int c = 0; c < 400; c++) begin
      tick_cycle(($urandom_range(0, 7) == 0), 4'($urandom));
    end

    // Reset mid-fade abandons it; nothing resumes afterwards.
    tick_cycle(1'b1, 4'b0000);
    run_until_idle(200, used);
    tick_cycle(1'b1, 4'b1010);
    for (int c = 0; c < 19; c++) tick_cycle(1'b0, 4'b0000);
    chk("pre_reset_busy", busy_a, 1);
    async_reset(3);
    for (int c = 0; c < 40; c++) tick_cycle(1'b0, 4'b0000);
    chk("no_resume_s1", levels_a, 0);
    chk("no_resume_s4", levels_b, 0);
    chk("no_resume_busy", {busy_a, busy_b}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
